// File: rtl/fetch_stage.sv
// MIPS IF stage: owns the PC, issues instruction-memory requests and holds the IF/ID register.
// Decode redirects and imem wait cycles become bubbles; a hazard stall freezes the whole stage.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             PCSrcD,
  input  logic             Jump,
  input  logic [31:0]      PCBranchD,
  input  logic [31:0]      JA,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCPlus4D,
  output logic             ValidD,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic             dbg_state
);

  // Instruction-memory handshake: imem_req qualifies imem_addr; imem_ready qualifies
  // imem_rdata for that same address in the same cycle. A word is accepted on an edge where
  // the stage is in RUN, not stalled, not redirected and imem_ready is high.

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0]      pc_plus4_f;
  logic [31:0]      redirect_pc;
  logic             unused_ja_hi;

  assign pc_plus4_f  = pc_q + 32'd4;
  // Jumps keep the 256 MB region of the instruction in Decode (its PC+4).
  assign redirect_pc = Jump ? {pc4_q[31:28], JA[27:0]} : PCBranchD;
  assign unused_ja_hi = ^JA[31:28];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
        instr_d = NOP;
        valid_d = 1'b0;
      end
      S_RUN: begin
        if (!stall) begin
          if (PCSrcD) begin
            // Wrong-path word is dropped even if imem answered; there is no delay slot.
            pc_d    = redirect_pc;
            instr_d = NOP;
            valid_d = 1'b0;
            pc4_d   = pc_plus4_f;
          end else if (!imem_ready) begin
            instr_d = NOP;
            valid_d = 1'b0;
          end else begin
            pc_d    = pc_plus4_f;
            instr_d = imem_rdata;
            pc4_d   = pc_plus4_f;
            valid_d = 1'b1;
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req  = (state_q == S_RUN) && !stall;
  assign imem_addr = pc_q;
  assign InstrD    = instr_q;
  assign PCPlus4D  = pc4_q;
  assign ValidD    = valid_q;
  assign fetch_cnt = cnt_q;
  assign dbg_state = (state_q == S_RUN);

endmodule
